// File: rtl/creek_instr_loader_if.sv
// -----------------------------------------------------------------------------
// creek_instr_loader_if
// Bus bundle between the program loader and its two neighbours: the DDR3
// controller's Avalon-MM local read interface and the instruction memory
// write port.
//   master : the loader (drives avl_read/avl_address and the instr_* port)
//   slave  : the DDR3 controller and instr_mem side
// Signals:
//   avl_ready          controller ready (inverse of waitrequest)
//   avl_read           read request
//   avl_address        DDR3 word address
//   avl_readdatavalid  read data valid
//   avl_readdata       read data beat
//   instr_writeaddr    instruction memory write address
//   instr_writedata    instruction word
//   instr_write        instruction memory write enable
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface creek_instr_loader_if #(
  parameter int AVL_ADDR_WIDTH  = 26,
  parameter int AVL_DATA_WIDTH  = 128,
  parameter int INSTR_WIDTH     = 16,
  parameter int IMEM_ADDR_WIDTH = 10
) ();
  logic                       avl_ready;
  logic                       avl_read;
  logic [AVL_ADDR_WIDTH-1:0]  avl_address;
  logic                       avl_readdatavalid;
  logic [AVL_DATA_WIDTH-1:0]  avl_readdata;
  logic [IMEM_ADDR_WIDTH-1:0] instr_writeaddr;
  logic [INSTR_WIDTH-1:0]     instr_writedata;
  logic                       instr_write;

  modport master (
    input  avl_ready, avl_readdatavalid, avl_readdata,
    output avl_read, avl_address, instr_writeaddr, instr_writedata, instr_write
  );

  modport slave (
    output avl_ready, avl_readdatavalid, avl_readdata,
    input  avl_read, avl_address, instr_writeaddr, instr_writedata, instr_write
  );
endinterface

// File: rtl/creek_instr_loader.sv
// -----------------------------------------------------------------------------
// creek_instr_loader
// Copies a program image from DDR3 into instruction memory. One 128-bit read
// is issued per beat (single outstanding read); each returned beat is split
// into eight 16-bit instructions, lowest halfword first, written on eight
// consecutive cycles to ascending instruction memory addresses from 0.
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      one-cycle load request, honoured only when idle
//   base_addr  first DDR3 word address (sampled with start)
//   num_beats  number of beats (sampled with start), 0 = empty, >128 -> 128
//   busy       high while a load is in progress
//   done       one-cycle completion pulse
//   bus        Avalon read master + instruction memory write port
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module creek_instr_loader #(
  parameter int AVL_ADDR_WIDTH  = 26,
  parameter int AVL_DATA_WIDTH  = 128,
  parameter int INSTR_WIDTH     = 16,
  parameter int IMEM_ADDR_WIDTH = 10
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [AVL_ADDR_WIDTH-1:0] base_addr,
  input  logic [7:0]                num_beats,
  output logic                      busy,
  output logic                      done,
  creek_instr_loader_if.master      bus
);

  localparam int SLOTS       = AVL_DATA_WIDTH / INSTR_WIDTH;
  localparam int SLOT_W      = $clog2(SLOTS);
  localparam int MAX_BEATS_I = (1 << IMEM_ADDR_WIDTH) / SLOTS;
  localparam logic [7:0] MAX_BEATS = 8'(MAX_BEATS_I);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, UNPACK, DONE} state_t;

  state_t                     state_q, state_d;
  logic [7:0]                 beats_q;
  logic [SLOT_W-1:0]          slot_q;
  logic [IMEM_ADDR_WIDTH-1:0] wr_addr_q;
  logic [AVL_DATA_WIDTH-1:0]  buf_q;
  logic [AVL_ADDR_WIDTH-1:0]  addr_q;
  logic                       read_q;
  logic                       write_q;
  logic [IMEM_ADDR_WIDTH-1:0] waddr_q;
  logic [INSTR_WIDTH-1:0]     wdata_q;
  logic                       busy_q;
  logic                       done_q;

  // The image can never exceed the instruction memory, so the beat count
  // is clamped to what fits.
  function automatic logic [7:0] sat_beats(input logic [7:0] n);
    return (n > MAX_BEATS) ? MAX_BEATS : n;
  endfunction

  // Next-state logic. In UNPACK, slot_q holds the index of the next halfword
  // to write; it wraps to 0 once the eighth write has been issued, and that
  // cycle ends the beat.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (sat_beats(num_beats) == 8'd0) ? DONE : REQ;
      REQ:     if (bus.avl_ready) state_d = WAIT;
      WAIT:    if (bus.avl_readdatavalid) state_d = UNPACK;
      UNPACK:  if (slot_q == '0) state_d = (beats_q == 8'd1) ? DONE : REQ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      beats_q   <= '0;
      slot_q    <= '0;
      wr_addr_q <= '0;
      addr_q    <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == REQ) || (state_d == WAIT) || (state_d == UNPACK);
      done_q  <= (state_d == DONE);
      read_q  <= (state_d == REQ);
      write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q    <= base_addr;
            beats_q   <= sat_beats(num_beats);
            wr_addr_q <= '0;
          end
        end
        WAIT: begin
          // Slot 0 is written straight from the bus so the first write lands
          // the cycle after the data returns.
          if (bus.avl_readdatavalid) begin
            write_q   <= 1'b1;
            wdata_q   <= bus.avl_readdata[INSTR_WIDTH-1:0];
            waddr_q   <= wr_addr_q;
            wr_addr_q <= wr_addr_q + 1'b1;
            slot_q    <= SLOT_W'(1);
          end
        end
        UNPACK: begin
          if (slot_q != '0) begin
            write_q   <= 1'b1;
            wdata_q   <= buf_q[INSTR_WIDTH*int'(slot_q) +: INSTR_WIDTH];
            waddr_q   <= wr_addr_q;
            wr_addr_q <= wr_addr_q + 1'b1;
            slot_q    <= slot_q + 1'b1;
          end else begin
            beats_q <= beats_q - 8'd1;
            if (beats_q != 8'd1) addr_q <= addr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Beat buffer: plain data, no reset needed
  always_ff @(posedge clock) begin
    if (state_q == WAIT && bus.avl_readdatavalid) buf_q <= bus.avl_readdata;
  end

  assign bus.avl_read        = read_q;
  assign bus.avl_address     = addr_q;
  assign bus.instr_write     = write_q;
  assign bus.instr_writeaddr = waddr_q;
  assign bus.instr_writedata = wdata_q;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule
